// File: rtl/riscv_structures.sv
// Shared RISC-V definitions used by the decode and encode paths.
package riscv_structures;

  typedef enum logic [2:0] {
    R_TYPE = 3'd0,
    I_TYPE = 3'd1,
    S_TYPE = 3'd2,
    B_TYPE = 3'd3,
    U_TYPE = 3'd4,
    J_TYPE = 3'd5
  } instr_type_e;

endpackage

// File: rtl/imm_encoder.sv
// Two-stage immediate packer: inserts a signed immediate into the type-specific
// fields of an instruction template, flags out-of-range/misaligned immediates.
module imm_encoder
  import riscv_structures::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  instr_type_e          in_type,
  input  logic [31:0]          in_template,
  input  logic [31:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  // Handshakes: a word moves when valid && ready on the same rising edge; a
  // producer holds valid and data stable until accepted; ready never waits on valid.

  logic        ready_en;
  logic        s1_valid;
  instr_type_e s1_type;
  logic [31:0] s1_template;
  logic [20:0] s1_imm;
  logic        s1_fit;

  logic        s2_adv;
  logic        s1_adv;
  logic        in_fire;
  logic        out_fire;
  logic        in_fit;
  logic [31:0] packed_word;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && ready_en;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Fit means every bit above the field's sign bit replicates it.
  always_comb begin
    in_fit = 1'b1;
    case (in_type)
      I_TYPE, S_TYPE: in_fit = (&in_imm[31:11]) || !(|in_imm[31:11]);
      B_TYPE:         in_fit = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
      J_TYPE:         in_fit = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
      default:        in_fit = 1'b1;
    endcase
  end

  always_comb begin
    packed_word = s1_template;
    case (s1_type)
      I_TYPE: packed_word[31:20] = s1_imm[11:0];
      S_TYPE: begin
        packed_word[31:25] = s1_imm[11:5];
        packed_word[11:7]  = s1_imm[4:0];
      end
      B_TYPE: begin
        packed_word[31]    = s1_imm[12];
        packed_word[30:25] = s1_imm[10:5];
        packed_word[11:8]  = s1_imm[4:1];
        packed_word[7]     = s1_imm[11];
      end
      J_TYPE: begin
        packed_word[31]    = s1_imm[20];
        packed_word[30:21] = s1_imm[10:1];
        packed_word[20]    = s1_imm[11];
        packed_word[19:12] = s1_imm[19:12];
      end
      default: packed_word = s1_template;
    endcase
  end

  // Holds in_ready low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_type     <= R_TYPE;
      s1_template <= '0;
      s1_imm      <= '0;
      s1_fit      <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_type     <= in_type;
        s1_template <= in_template;
        s1_imm      <= in_imm[20:0];
        s1_fit      <= in_fit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= packed_word;
        out_err   <= !s1_fit;
      end
    end
  end

  // Clear takes priority over a coincident errored handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (out_fire && out_err && (err_count != '1)) begin
      err_count <= err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed vector table, directed
// backpressure/clear/reset sequences, and a randomized scoreboarded stream.
module tb_imm_encoder;
  import riscv_structures::*;

  typedef struct {
    instr_type_e typ;
    logic [31:0] tmpl;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  instr_type_e in_type;
  logic [31:0] in_template;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        err_clr;
  logic [7:0]  err_count;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cnt_model = 0;
  int delivered = 0;

  vec_t        src_q[$];
  logic [32:0] exp_q[$];
  logic        hold_in    = 1'b0;
  logic        prev_stall = 1'b0;
  logic [32:0] prev_word  = '0;

  imm_encoder #(.ERR_CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_type    (in_type),
    .in_template(in_template),
    .in_imm     (in_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .err_clr    (err_clr),
    .err_count  (err_count)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Which immediate bit lands on instruction bit pos (-1: template bit).
  function automatic int imm_src(instr_type_e t, int pos);
    case (t)
      I_TYPE: return (pos >= 20) ? pos - 20 : -1;
      S_TYPE: begin
        if (pos >= 25) return pos - 20;
        if (pos >= 7 && pos <= 11) return pos - 7;
        return -1;
      end
      B_TYPE: begin
        if (pos == 31) return 12;
        if (pos >= 25) return pos - 20;
        if (pos >= 8 && pos <= 11) return pos - 7;
        if (pos == 7) return 11;
        return -1;
      end
      J_TYPE: begin
        if (pos == 31) return 20;
        if (pos >= 21) return pos - 20;
        if (pos == 20) return 11;
        if (pos >= 12 && pos <= 19) return pos;
        return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic logic [31:0] model_pack(instr_type_e t, logic [31:0] tmpl, logic [31:0] imm);
    logic [31:0] w;
    w = tmpl;
    for (int p = 0; p < 32; p++) begin
      int s;
      s = imm_src(t, p);
      if (s >= 0) w[p] = imm[s];
    end
    return w;
  endfunction

  function automatic logic model_err(instr_type_e t, logic [31:0] imm);
    longint v;
    v = longint'($signed(imm));
    case (t)
      I_TYPE, S_TYPE: return !(v >= -2048 && v <= 2047);
      B_TYPE:         return !(v >= -4096 && v <= 4095) || (v % 2 != 0);
      J_TYPE:         return !(v >= -1048576 && v <= 1048575) || (v % 2 != 0);
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_decode(instr_type_e t, logic [31:0] w);
    logic [31:0] v;
    int top;
    v = '0;
    for (int p = 0; p < 32; p++) begin
      int s;
      s = imm_src(t, p);
      if (s >= 0) v[s] = w[p];
    end
    top = (t == B_TYPE) ? 12 : (t == J_TYPE) ? 20 : 11;
    for (int b = top + 1; b < 32; b++) v[b] = v[top];
    return v;
  endfunction

  function automatic logic [31:0] rand_imm();
    int r;
    int edges[11] = '{2047, -2048, 2048, -2049, 4095, -4096, 4094, 1048575, -1048576, 1048574, -1048578};
    case ($urandom_range(0, 3))
      0:       r = int'($urandom_range(0, 8191)) - 4096;
      1:       r = int'($urandom_range(0, 2097151)) - 1048576;
      2:       r = int'($urandom);
      default: r = edges[$urandom_range(0, 10)];
    endcase
    return r;
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int sat_inc(int c);
    return (c >= 255) ? 255 : c + 1;
  endfunction

  // ---------------- driver tasks ----------------
  // One word, unstalled; checks latency, packing, round trip and counter.
  task automatic send_one(input vec_t v, input string name, input logic clr_at_out);
    int cyc;
    cyc = 0;
    out_ready   = 1'b1;
    in_type     = v.typ;
    in_template = v.tmpl;
    in_imm      = v.imm;
    in_valid    = 1'b1;
    while (!in_ready && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, " in_ready"}, 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_imm   = $urandom;
    chk({name, " not early"}, 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    chk({name, " out_valid"}, 64'(out_valid), 64'(1));
    chk({name, " out_instr"}, 64'(out_instr), 64'(v.exp_instr));
    chk({name, " out_err"}, 64'(out_err), 64'(v.exp_err));
    if (!v.exp_err && v.typ inside {I_TYPE, S_TYPE, B_TYPE, J_TYPE})
      chk({name, " round trip"}, 64'(model_decode(v.typ, out_instr)), 64'(v.imm));
    if (clr_at_out) begin
      err_clr   = 1'b1;
      cnt_model = 0;
    end else if (v.exp_err) begin
      cnt_model = sat_inc(cnt_model);
    end
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk({name, " drained"}, 64'(out_valid), 64'(0));
    chk({name, " err_count"}, 64'(err_count), 64'(cnt_model));
  endtask

  // One streaming cycle: drive from src_q, score outputs against exp_q.
  task automatic step(input logic rdy, input logic allow);
    logic acc;
    logic [32:0] e;
    out_ready = rdy;
    if (src_q.size() != 0 && (hold_in || allow)) begin
      in_type     = src_q[0].typ;
      in_template = src_q[0].tmpl;
      in_imm      = src_q[0].imm;
      in_valid    = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    acc = in_valid && in_ready;
    if (acc) begin
      exp_q.push_back({model_err(src_q[0].typ, src_q[0].imm),
                       model_pack(src_q[0].typ, src_q[0].tmpl, src_q[0].imm)});
      void'(src_q.pop_front());
    end
    hold_in = in_valid && !acc;
    if (prev_stall)
      chk("stall hold", {30'd0, out_valid, out_err, out_instr}, {30'd0, 1'b1, prev_word});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected output: got 0x%0h expected none", out_instr);
      end else begin
        e = exp_q.pop_front();
        chk("stream word", 64'({out_err, out_instr}), 64'(e));
        if (e[32]) cnt_model = sat_inc(cnt_model);
      end
      delivered++;
    end
    prev_stall = out_valid && !out_ready;
    prev_word  = {out_err, out_instr};
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    chk("drain done", 64'(src_q.size() + exp_q.size()), 64'(0));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[8];
    vec_t v;

    vecs[0] = '{I_TYPE, 32'h00000093, 32'hFFFFFFFF, 32'hFFF00093, 1'b0};
    vecs[1] = '{S_TYPE, 32'h0020A023, 32'h00000008, 32'h0020A423, 1'b0};
    vecs[2] = '{B_TYPE, 32'h00000063, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0};
    vecs[3] = '{J_TYPE, 32'h000000EF, 32'h00000800, 32'h001000EF, 1'b0};
    vecs[4] = '{U_TYPE, 32'h12345037, 32'hFFFFFFFF, 32'h12345037, 1'b0};
    vecs[5] = '{I_TYPE, 32'hABC00093, 32'h00000005, 32'h00500093, 1'b0};
    vecs[6] = '{I_TYPE, 32'h00000093, 32'h00000800, 32'h80000093, 1'b1};
    vecs[7] = '{B_TYPE, 32'h00000063, 32'h00000003, 32'h00000163, 1'b1};

    // clock / reset
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_type     = R_TYPE;
    in_template = '0;
    in_imm      = '0;
    out_ready   = 1'b1;
    err_clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'(0));
    chk("reset out_instr", 64'(out_instr), 64'(0));
    chk("reset out_err", 64'(out_err), 64'(0));
    chk("reset err_count", 64'(err_count), 64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready after reset", 64'(in_ready), 64'(1));

    // directed table; err_count steps 0 -> 1 -> 2 over the last two
    for (int i = 0; i < 8; i++) send_one(vecs[i], $sformatf("vec%0d", i), 1'b0);

    // clear coinciding with a third errored handshake
    v = '{J_TYPE, 32'h000000EF, 32'h00000001, 32'h000000EF, 1'b1};
    send_one(v, "clr_vs_inc", 1'b1);

    // backpressure: 5 words, output stalled for 4 cycles once both stages fill
    for (int i = 0; i < 5; i++) begin
      v.typ  = I_TYPE;
      v.tmpl = 32'h00000013 | (32'(i) << 7);
      v.imm  = 32'(i * 100 - 150);
      src_q.push_back(v);
    end
    prev_stall = 1'b0;
    hold_in    = 1'b0;
    delivered  = 0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("bp in_ready low", 64'(in_ready), 64'(0));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1);
      chk("bp in_ready held", 64'(in_ready), 64'(0));
    end
    drain(50);
    chk("bp delivered", 64'(delivered), 64'(5));

    // randomized stream against the model
    for (int i = 0; i < 200; i++) begin
      v.typ  = instr_type_e'($urandom_range(0, 5));
      v.tmpl = $urandom;
      v.imm  = rand_imm();
      src_q.push_back(v);
    end
    delivered = 0;
    for (int c = 0; c < 3000 && (src_q.size() != 0 || exp_q.size() != 0); c++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    drain(50);
    chk("rand delivered", 64'(delivered), 64'(200));
    chk("rand err_count", 64'(err_count), 64'(cnt_model));

    // saturation after 300 errored words
    for (int i = 0; i < 300; i++) begin
      v.typ  = I_TYPE;
      v.tmpl = $urandom;
      v.imm  = 32'h00000800 + 32'($urandom_range(0, 1000));
      src_q.push_back(v);
    end
    drain(1000);
    chk("sat err_count", 64'(err_count), 64'(255));
    chk("sat model", 64'(err_count), 64'(cnt_model));

    // reset mid-flight with both stages full
    for (int i = 0; i < 2; i++) begin
      v.typ  = S_TYPE;
      v.tmpl = $urandom;
      v.imm  = rand_imm();
      src_q.push_back(v);
    end
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    chk("pre-reset full", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'(0));
    chk("async err_count", 64'(err_count), 64'(0));
    chk("async out_instr", 64'(out_instr), 64'(0));
    src_q.delete();
    exp_q.delete();
    in_valid   = 1'b0;
    hold_in    = 1'b0;
    prev_stall = 1'b0;
    cnt_model  = 0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset in_ready", 64'(in_ready), 64'(1));
    chk("no replay", 64'(out_valid), 64'(0));
    send_one(vecs[2], "post-reset", 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
